// File: rtl/avalon_uart_bridge_v2.sv
// UART-to-Avalon-MM command bridge: 8N1 receiver/transmitter plus a command FSM that
// turns {rnw,idx} + little-endian data bytes into single Avalon reads/writes.
//
// state     | meaning
// S_IDLE    | waiting for a command byte
// S_GETDATA | collecting NB write-data bytes, inter-byte timeout armed
// S_AVWRITE | Avalon write in flight
// S_AVREAD  | Avalon read in flight
// S_SEND    | shifting read data out on TX, LSB byte first
module avalon_uart_bridge_v2 #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          TIMEOUT_CLKS = 8680
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX,
    output logic              TX,
    output logic [31:0]       ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              WAITREQUEST,
    output logic              READ,
    output logic              WRITE,
    output logic              BEGINTRANSFER,
    output logic              LOCK,
    output logic              busy,
    output logic              done,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int          NB    = DATA_W / 8;
    localparam int          BC_W  = $clog2(NB) + 1;
    localparam int          CNT_W = $clog2(CLKS_PER_BIT);
    localparam int          TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int          HALF  = CLKS_PER_BIT / 2;
    localparam logic [31:0] NB32  = 32'(NB);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_GETDATA, S_AVWRITE, S_AVREAD, S_SEND} state_t;

    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sr, rx_byte;
    logic             rx_valid, rx_ferr;

    state_t           state;
    logic [BC_W-1:0]  byte_cnt, tx_byte;
    logic [TO_W-1:0]  to_cnt;
    logic [DATA_W-1:0] data_sr, data_next, rd_word;
    logic [9:0]       tx_frame;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;

    assign LOCK = 1'b0;
    assign busy = (state != S_IDLE);

    // Receiver. The start-bit delay is shortened by two to absorb the synchroniser
    // latency, so every sample lands near the bit centre.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sr    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt   <= CNT_W'(HALF - 2);
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (!rx_s) begin
                        rx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                        rx_bit   <= '0;
                        rx_state <= R_DATA;
                    end else begin
                        rx_state <= R_IDLE;
                    end
                end
                R_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_sr  <= {rx_s, rx_sr[7:1]};
                        rx_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_byte  <= rx_sr;
                        rx_valid <= rx_s;
                        rx_ferr  <= !rx_s;
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        data_next = data_sr;
        for (int b = 0; b < NB; b++) begin
            if (byte_cnt == BC_W'(b)) data_next[8*b +: 8] = rx_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            TX            <= 1'b1;
            ADDRESS       <= '0;
            WRITEDATA     <= '0;
            READ          <= 1'b0;
            WRITE         <= 1'b0;
            BEGINTRANSFER <= 1'b0;
            done          <= 1'b0;
            err_frame     <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            byte_cnt      <= '0;
            tx_byte       <= '0;
            to_cnt        <= '0;
            data_sr       <= '0;
            rd_word       <= '0;
            tx_frame      <= '1;
            tx_cnt        <= '0;
            tx_bit        <= '0;
        end else begin
            done        <= 1'b0;
            err_frame   <= rx_ferr;
            err_timeout <= 1'b0;
            err_overrun <= rx_valid && (state == S_AVWRITE || state == S_AVREAD ||
                                        state == S_SEND);
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        ADDRESS  <= BASE_ADDR + {25'd0, rx_byte[6:0]} * NB32;
                        byte_cnt <= '0;
                        to_cnt   <= TO_W'(TIMEOUT_CLKS - 1);
                        state    <= rx_byte[7] ? S_AVREAD : S_GETDATA;
                    end
                end
                S_GETDATA: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rx_valid) begin
                        data_sr <= data_next;
                        to_cnt  <= TO_W'(TIMEOUT_CLKS - 1);
                        if (byte_cnt == BC_W'(NB - 1)) begin
                            WRITEDATA <= data_next;
                            state     <= S_AVWRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (rx_ferr) begin
                        state <= S_IDLE;
                    end else if (to_cnt == '0) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_AVWRITE: begin
                    if (!WRITE) begin
                        WRITE         <= 1'b1;
                        BEGINTRANSFER <= 1'b1;
                    end else begin
                        BEGINTRANSFER <= 1'b0;
                        if (!WAITREQUEST) begin
                            WRITE <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_AVREAD: begin
                    if (!READ) begin
                        READ          <= 1'b1;
                        BEGINTRANSFER <= 1'b1;
                    end else begin
                        BEGINTRANSFER <= 1'b0;
                        if (!WAITREQUEST) begin
                            READ     <= 1'b0;
                            rd_word  <= READDATA >> 8;
                            tx_frame <= {1'b1, READDATA[7:0], 1'b0};
                            TX       <= 1'b0;
                            tx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                            tx_bit   <= '0;
                            tx_byte  <= '0;
                            state    <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else if (tx_bit != 4'd9) begin
                        tx_frame <= {1'b1, tx_frame[9:1]};
                        TX       <= tx_frame[1];
                        tx_bit   <= tx_bit + 1'b1;
                        tx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                    end else if (tx_byte == BC_W'(NB - 1)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tx_byte  <= tx_byte + 1'b1;
                        tx_frame <= {1'b1, rd_word[7:0], 1'b0};
                        rd_word  <= rd_word >> 8;
                        TX       <= 1'b0;
                        tx_bit   <= '0;
                        tx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_uart_bridge_v2.sv
// Scoreboard bench for avalon_uart_bridge_v2: expected Avalon transfers and TX bytes are
// queued when commands are sent and checked by monitors as the bridge produces them.
module tb_avalon_uart_bridge_v2;

    localparam int          CPB  = 8;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h100;

    logic          CLK = 1'b0, RST = 1'b1, RX = 1'b1, WAITREQUEST = 1'b0;
    logic [DW-1:0] READDATA = '0;
    logic          TX, READ, WRITE, BEGINTRANSFER, LOCK, busy, done;
    logic          err_frame, err_timeout, err_overrun;
    logic [31:0]   ADDRESS;
    logic [DW-1:0] WRITEDATA;

    always #5 CLK = ~CLK;

    avalon_uart_bridge_v2 #(
        .CLKS_PER_BIT(CPB), .DATA_W(DW), .BASE_ADDR(BASE), .TIMEOUT_CLKS(8680)
    ) dut (
        .CLK(CLK), .RST(RST), .RX(RX), .TX(TX), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .WAITREQUEST(WAITREQUEST), .READ(READ), .WRITE(WRITE),
        .BEGINTRANSFER(BEGINTRANSFER), .LOCK(LOCK), .busy(busy), .done(done),
        .err_frame(err_frame), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
    } av_t;

    av_t        exp_av[$];
    logic [7:0] exp_tx[$];
    int n_done = 0, n_frame = 0, n_to = 0, n_ovr = 0;
    int e_done = 0, e_frame = 0, e_to = 0, e_ovr = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (done)        n_done++;
            if (err_frame)   n_frame++;
            if (err_timeout) n_to++;
            if (err_overrun) n_ovr++;
        end
    end

    // Avalon slave model + monitor
    logic in_xfer = 1'b0, done_due = 1'b0;
    int   hold = 0, wait_left = 0;
    av_t  cur;
    always @(negedge CLK) begin
        if (RST) begin
            in_xfer     = 1'b0;
            done_due    = 1'b0;
            WAITREQUEST = 1'b0;
        end else begin
            if (done_due) begin
                chk_eq("done_after_write", done, 1);
                done_due = 1'b0;
            end
            if (READ || WRITE) begin
                chk_eq("rw_exclusive", READ & WRITE, 0);
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    hold    = 0;
                    chk_eq("begintransfer_first", BEGINTRANSFER, 1);
                    chk_eq("av_pending", exp_av.size() != 0, 1);
                    if (exp_av.size() != 0) cur = exp_av.pop_front();
                    wait_left = cur.waits;
                    chk_eq("av_rnw", READ, cur.rnw);
                end else begin
                    chk_eq("begintransfer_later", BEGINTRANSFER, 0);
                end
                chk_eq("av_addr", ADDRESS, cur.addr);
                if (!cur.rnw) chk_eq("av_wdata", WRITEDATA, cur.data);
                hold++;
                if (wait_left > 0) begin
                    WAITREQUEST = 1'b1;
                    wait_left--;
                end else begin
                    WAITREQUEST = 1'b0;
                    chk_eq("strobe_cycles", hold, cur.waits + 1);
                    in_xfer  = 1'b0;
                    done_due = !cur.rnw;
                end
            end
        end
    end

    // TX line decoder
    initial begin
        logic       prev, start_b, stop_b;
        logic [7:0] b, e;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (prev && TX === 1'b0 && !RST) begin
                repeat (CPB/2) @(negedge CLK);
                start_b = TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = TX;
                end
                repeat (CPB) @(negedge CLK);
                stop_b = TX;
                chk_eq("tx_start", start_b, 0);
                chk_eq("tx_stop", stop_b, 1);
                chk_eq("tx_pending", exp_tx.size() != 0, 1);
                e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
                chk_eq("tx_byte", b, e);
            end
            prev = (TX === 1'b1);
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX = stop;
        repeat (CPB) @(negedge CLK);
        RX = 1'b1;
        if (!stop) repeat (CPB) @(negedge CLK);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) @(negedge CLK);
        chk_eq(tag, busy, 0);
    endtask

    task automatic chk_counts(input string tag);
        chk_eq({tag, "_done"}, n_done, e_done);
        chk_eq({tag, "_err_frame"}, n_frame, e_frame);
        chk_eq({tag, "_err_timeout"}, n_to, e_to);
        chk_eq({tag, "_err_overrun"}, n_ovr, e_ovr);
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_eq("rst_tx", TX, 1);
        chk_eq("rst_read", READ, 0);
        chk_eq("rst_write", WRITE, 0);
        chk_eq("rst_bt", BEGINTRANSFER, 0);
        chk_eq("rst_lock", LOCK, 0);
        chk_eq("rst_addr", ADDRESS, 0);
        chk_eq("rst_wdata", WRITEDATA, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_err", {err_frame, err_timeout, err_overrun}, 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // write, no wait states
        exp_av.push_back('{1'b0, 32'h114, 32'h12345678, 0});
        e_done++;
        uart_send(8'h05, 1'b1);
        chk_eq("t1_busy_getdata", busy, 1);
        uart_send(8'h78, 1'b1);
        uart_send(8'h56, 1'b1);
        uart_send(8'h34, 1'b1);
        uart_send(8'h12, 1'b1);
        wait_idle("t1_idle", 200);
        repeat (5) @(negedge CLK);
        chk_counts("t1");

        // read with 3 wait states, plus an overrun byte during SEND
        READDATA = 32'hDEADBEEF;
        exp_av.push_back('{1'b1, 32'h10C, 32'h0, 3});
        exp_tx.push_back(8'hEF);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hDE);
        e_done++;
        e_ovr++;
        uart_send(8'h83, 1'b1);
        repeat (20) @(negedge CLK);
        chk_eq("t2_busy_send", busy, 1);
        uart_send(8'h55, 1'b1);
        wait_idle("t2_idle", 1000);
        repeat (10) @(negedge CLK);
        chk_eq("t2_tx_drained", exp_tx.size(), 0);
        chk_counts("t2");

        // partial write then silence
        uart_send(8'h01, 1'b1);
        uart_send(8'hAA, 1'b1);
        uart_send(8'hBB, 1'b1);
        chk_eq("t3_busy", busy, 1);
        e_to++;
        repeat (9000) @(negedge CLK);
        chk_eq("t3_busy_after", busy, 0);
        chk_counts("t3");

        // framing error on command, then a normal write
        e_frame++;
        uart_send(8'h02, 1'b0);
        repeat (5) @(negedge CLK);
        chk_eq("t5_busy", busy, 0);
        exp_av.push_back('{1'b0, 32'h108, 32'h44332211, 1});
        e_done++;
        uart_send(8'h02, 1'b1);
        uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        uart_send(8'h33, 1'b1);
        uart_send(8'h44, 1'b1);
        wait_idle("t5_idle", 200);
        repeat (5) @(negedge CLK);
        chk_counts("t5");

        // reset while the slave stalls a write
        exp_av.push_back('{1'b0, 32'h11C, 32'hCAFEF00D, 1000});
        uart_send(8'h07, 1'b1);
        uart_send(8'h0D, 1'b1);
        uart_send(8'hF0, 1'b1);
        uart_send(8'hFE, 1'b1);
        uart_send(8'hCA, 1'b1);
        for (int i = 0; i < 200 && !WRITE; i++) @(negedge CLK);
        chk_eq("t6_write_seen", WRITE, 1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_eq("t6_write", WRITE, 0);
        chk_eq("t6_bt", BEGINTRANSFER, 0);
        chk_eq("t6_tx", TX, 1);
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_addr", ADDRESS, 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        chk_eq("av_drained", exp_av.size(), 0);
        chk_counts("final");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
